// File: rtl/uart_tx_pkg.sv
// Shared constants for the board UART transmitter.
// Define UART_TX_PARITY_EN for an 8E1 frame; the default build is 8N1.
package uart_tx_pkg;

    localparam int B115200 = 104;
    localparam int B57600  = 208;
    localparam int B38400  = 313;
    localparam int B19200  = 625;
    localparam int B9600   = 1250;
    localparam int B4800   = 2500;
    localparam int B2400   = 5000;
    localparam int B1200   = 10000;
    localparam int B600    = 20000;
    localparam int B300    = 40000;

    typedef enum logic {
        IDLE  = 1'b0,
        TRANS = 1'b1
    } state_t;

    localparam int DATA_BITS = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    // idle + start + data + [parity] + stop; also the tick count per frame
    localparam int NB = DATA_BITS + PAR_BITS + 3;

    function automatic logic [NB-1:0] frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^d, d, 1'b0, 1'b1};
`else
        return {1'b1, d, 1'b0, 1'b1};
`endif
    endfunction

endpackage

// File: rtl/uart_tx_baudgen.sv
// Bit-rate tick generator for the transmitter.
// Emits a one-cycle clk_out pulse every BAUDRATE cycles while enabled.
module baudgen_tx
    import uart_tx_pkg::*;
#(
    parameter int BAUDRATE = B115200
) (
    input  logic clk,
    input  logic rstn,
    input  logic clk_ena,
    output logic clk_out
);

    localparam int CW = (BAUDRATE > 1) ? $clog2(BAUDRATE) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUDRATE - 1);

    logic [CW-1:0] cnt;

    // Parked at LAST so the first tick lands one cycle after enable.
    always_ff @(posedge clk) begin
        if (!rstn || !clk_ena) begin
            cnt <= LAST;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign clk_out = clk_ena && (cnt == '0);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per start/ready handshake, 8N1 on tx.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int BAUDRATE = B115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int CNTW = $clog2(NB + 1);

    state_t          state;
    state_t          state_next;
    logic [NB-1:0]   shifter;
    logic [CNTW-1:0] bitc;
    logic            tick;
    logic            ena;
    logic            load;
    logic            last;

    baudgen_tx #(
        .BAUDRATE(BAUDRATE)
    ) u_baud (
        .clk    (clk),
        .rstn   (rstn),
        .clk_ena(ena),
        .clk_out(tick)
    );

    assign last = (bitc == CNTW'(NB - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start) state_next = TRANS;
            TRANS: if (tick && last) state_next = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        ena   = (state == TRANS);
        load  = (state == IDLE) && start;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            shifter <= '1;
            bitc    <= '0;
            tx      <= 1'b1;
        end else begin
            tx <= shifter[0];
            if (load) begin
                shifter <= frame(data);
                bitc    <= '0;
            end else if (tick) begin
                shifter <= {1'b1, shifter[NB-1:1]};
                bitc    <= bitc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx with BAUDRATE=4.
// A line monitor decodes frames against a scoreboard of sent bytes.
`timescale 1ns/1ps
module tb_uart_tx;

    localparam int B = 4;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NB = 11 + P;
    localparam int NBITS = NB - 1;
    localparam int RDY = 2 + (NB - 1) * B;

    typedef struct {
        logic [7:0] d;
        int         s;
    } exp_t;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data = 8'h00;
    logic       tx;
    logic       ready;

    int   cyc = 0;
    int   vectors = 0;
    int   errors = 0;
    int   nframes = 0;
    bit   mon_en = 1'b1;
    bit   mon_busy = 1'b0;
    exp_t q[$];

    uart_tx #(
        .BAUDRATE(B)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .start(start),
        .data (data),
        .tx   (tx),
        .ready(ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1);
    end

    initial begin : monitor
        logic             prev;
        exp_t             e;
        logic [7:0]       got;
        logic [NBITS-1:0] fr;
        logic             bad;
        logic             badv;
        int               badc;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && rstn === 1'b1 && prev === 1'b1 && tx === 1'b0) begin
                mon_busy = 1'b1;
                nframes++;
                vectors++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_unexpected: start bit at cycle %0d, required none", cyc);
                end else begin
                    e = q.pop_front();
                    if (cyc !== e.s) begin
                        errors++;
                        $display("FAIL frame_start: start bit at cycle %0d, required %0d", cyc, e.s);
                    end
`ifdef UART_TX_PARITY_EN
                    fr = {1'b1, ^e.d, e.d, 1'b0};
`else
                    fr = {1'b1, e.d, 1'b0};
`endif
                    got = '0;
                    for (int j = 0; j < NBITS; j++) begin
                        bad = 1'b0;
                        badv = 1'b0;
                        badc = 0;
                        for (int t = 0; t < B; t++) begin
                            if (j != 0 || t != 0) @(negedge clk);
                            if (j >= 1 && j <= 8 && t == 0) got[j-1] = tx;
                            if (tx !== fr[j] && !bad) begin
                                bad = 1'b1;
                                badv = tx;
                                badc = cyc;
                            end
                        end
                        vectors++;
                        if (bad) begin
                            errors++;
                            $display("FAIL frame_bit%0d: tx=%b at cycle %0d, required %b (byte %h)",
                                     j, badv, badc, fr[j], e.d);
                        end
                    end
                    vectors++;
                    if (got !== e.d) begin
                        errors++;
                        $display("FAIL frame_byte: decoded %h, required %h", got, e.d);
                    end
                end
                mon_busy = 1'b0;
            end
            prev = tx;
        end
    end

    task automatic wait_ready(input int limit, output int at);
        int n;
        n = 0;
        at = -1;
        while (n < limit) begin
            @(negedge clk);
            if (ready === 1'b1) begin
                at = cyc;
                break;
            end
            n++;
        end
        vectors++;
        if (at < 0) begin
            errors++;
            $display("FAIL ready_timeout: ready=%b after %0d cycles, required 1", ready, limit);
        end
    endtask

    task automatic send(input logic [7:0] d, input bit track, output int e0);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        data = d;
        @(posedge clk);
        #1;
        e0 = cyc;
        if (track) begin
            e.d = d;
            e.s = e0 + 3;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        data = 8'($urandom);
    endtask

    task automatic test_reset();
        bit tick_seen;
        bit line_bad;
        tick_seen = 1'b0;
        line_bad = 1'b0;
        rstn = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL reset_tx: tx=%b, required 1", tx);
        end
        vectors++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: ready=%b, required 1", ready);
        end
        rstn = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (dut.tick !== 1'b0) tick_seen = 1'b1;
            if (tx !== 1'b1 || ready !== 1'b1) line_bad = 1'b1;
        end
        vectors++;
        if (tick_seen) begin
            errors++;
            $display("FAIL idle_tick: tick seen while idle, required none");
        end
        vectors++;
        if (line_bad) begin
            errors++;
            $display("FAIL idle_line: tx/ready left 1/1 while idle, required 1/1");
        end
    endtask

    task automatic test_single();
        int e0;
        int at;
        bit bad;
        bad = 1'b0;
        wait_ready(10, at);
        send(8'h55, 1'b1, e0);
        while (cyc < e0 + RDY) begin
            if (ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (bad) begin
            errors++;
            $display("FAIL single_busy: ready high before cycle %0d, required 0", e0 + RDY);
        end
        vectors++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready: ready=%b at E0+%0d, required 1", ready, RDY);
        end
    endtask

    task automatic test_busy_ignore();
        int e0;
        int at;
        int n0;
        bit quiet_bad;
        quiet_bad = 1'b0;
        wait_ready(10, at);
        n0 = nframes;
        send(8'h55, 1'b1, e0);
        while (cyc < e0 + 9) @(negedge clk);
        start = 1'b1;
        data = 8'hFF;
        @(negedge clk);
        start = 1'b0;
        wait_ready(NB * B + 10, at);
        vectors++;
        if (at !== e0 + RDY) begin
            errors++;
            $display("FAIL busy_ready_time: ready rose at E0+%0d, required E0+%0d", at - e0, RDY);
        end
        repeat (4 * B) begin
            @(negedge clk);
            if (tx !== 1'b1) quiet_bad = 1'b1;
        end
        vectors++;
        if (nframes - n0 !== 1) begin
            errors++;
            $display("FAIL busy_frames: %0d frames, required 1", nframes - n0);
        end
        vectors++;
        if (quiet_bad) begin
            errors++;
            $display("FAIL busy_quiet: tx left idle after frame, required 1");
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   e0;
        int   at;
        wait_ready(10, at);
        @(negedge clk);
        start = 1'b1;
        data = 8'h00;
        @(posedge clk);
        #1;
        e0 = cyc;
        e.d = 8'h00;
        e.s = e0 + 3;
        q.push_back(e);
        @(negedge clk);
        data = 8'hA5;
        wait_ready(NB * B + 10, at);
        vectors++;
        if (at !== e0 + RDY) begin
            errors++;
            $display("FAIL b2b_ready_time: ready rose at E0+%0d, required E0+%0d", at - e0, RDY);
        end
        e.d = 8'hA5;
        e.s = at + 4;
        q.push_back(e);
        @(negedge clk);
        vectors++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reaccept: ready=%b after re-accept, required 0", ready);
        end
        start = 1'b0;
        wait_ready(NB * B + 10, at);
    endtask

    task automatic test_reset_mid();
        int e0;
        int at;
        bit bad;
        bad = 1'b0;
        wait_ready(10, at);
        mon_en = 1'b0;
        send(8'h99, 1'b0, e0);
        while (cyc < e0 + 14) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        vectors++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL midrst_tx: tx=%b after reset edge, required 1", tx);
        end
        vectors++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL midrst_ready: ready=%b after reset edge, required 1", ready);
        end
        rstn = 1'b1;
        repeat (3 * B) begin
            @(negedge clk);
            if (tx !== 1'b1 || ready !== 1'b1) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            errors++;
            $display("FAIL midrst_resume: partial frame resumed, required idle");
        end
        mon_en = 1'b1;
        send(8'h3C, 1'b1, e0);
        wait_ready(NB * B + 10, at);
        vectors++;
        if (at !== e0 + RDY) begin
            errors++;
            $display("FAIL midrst_ready_time: ready rose at E0+%0d, required E0+%0d", at - e0, RDY);
        end
    endtask

    task automatic test_random();
        int         e0;
        int         at;
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            wait_ready(NB * B + 10, at);
            d = 8'($urandom);
            send(d, 1'b1, e0);
            wait_ready(NB * B + 10, at);
            vectors++;
            if (at !== e0 + RDY) begin
                errors++;
                $display("FAIL rand_ready_time: byte %h ready at E0+%0d, required E0+%0d",
                         d, at - e0, RDY);
            end
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int         e0;
        int         at;
        logic [7:0] pat [2];
        pat[0] = 8'h07;
        pat[1] = 8'h03;
        for (int i = 0; i < 2; i++) begin
            wait_ready(NB * B + 10, at);
            send(pat[i], 1'b1, e0);
            wait_ready(NB * B + 10, at);
            vectors++;
            if (at !== e0 + 2 + 11 * B) begin
                errors++;
                $display("FAIL parity_ready_time: ready at E0+%0d, required E0+%0d",
                         at - e0, 2 + 11 * B);
            end
        end
    endtask
`endif

    initial begin : main
        int n;
        test_reset();
        test_single();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        n = 0;
        while ((q.size() != 0 || mon_busy) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: %0d frames outstanding, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
